// File: rtl/function_sweep_controller_pkg.sv
// Shared definitions for the truth-table sweep engine: state encoding,
// counter widths and reference truth tables of the lab functions.
package function_sweep_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int CNT_W = 4;
  localparam int IDX_W = 3;

  // Bit i of each table is f({a,b,c} = i).
  localparam logic [7:0] EXP_NOT_A_OR_B_NOT_C = 8'h4F;
  localparam logic [7:0] EXP_MAJORITY         = 8'hE8;
  localparam logic [7:0] EXP_XOR3             = 8'h96;

  function automatic logic [CNT_W-1:0] settle_load(input int settle_cycles);
    return CNT_W'(settle_cycles - 1);
  endfunction

endpackage

// File: rtl/function_sweep_controller_settle_timer.sv
// Loadable down-counter; expired_o is high while the count sits at zero.
module function_sweep_controller_settle_timer
  import function_sweep_controller_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/function_sweep_controller.sv
// Steps {a,b,c} through all eight codes, samples f_in after a settle delay,
// and compares the assembled truth table against EXPECTED.
module function_sweep_controller
  import function_sweep_controller_pkg::*;
#(
  parameter int         SETTLE_CYCLES = 2,
  parameter logic [7:0] EXPECTED      = EXP_NOT_A_OR_B_NOT_C
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       c,
  input  logic       f_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_out,
  output logic       pass
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = settle_load(SETTLE_CYCLES);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [7:0]       table_q;
  logic             pass_q;

  logic accept;
  logic tmr_load;
  logic tmr_expired;

  // A start still high in DONE chains straight into the next sweep, so
  // back-to-back sweeps cost no idle cycle.
  assign accept   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign tmr_load = accept || (state_q == ST_SAMPLE);

  function_sweep_controller_settle_timer #(
    .W(CNT_W)
  ) u_settle_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (SETTLE_LOAD),
    .en_i       (state_q == ST_SETTLE),
    .expired_o  (tmr_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      table_q <= '0;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            state_q <= ST_SETTLE;
            idx_q   <= '0;
            table_q <= '0;
            pass_q  <= 1'b0;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_SETTLE: begin
          if (tmr_expired) begin
            state_q <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          table_q[idx_q] <= f_in;
          // The last bit is still in flight, so compare with it spliced in.
          if (idx_q == 3'd7) begin
            state_q <= ST_DONE;
            pass_q  <= ({f_in, table_q[6:0]} == EXPECTED);
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= ST_SETTLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign {a, b, c}  = idx_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign table_out  = table_q;
  assign pass       = pass_q;

endmodule

// File: tb/tb_function_sweep_controller.sv
// Scoreboard bench: expected sweep results are queued at start and checked
// against done pulses; a second instance runs with a one-cycle settle delay.
module tb_function_sweep_controller;

  typedef struct {
    int         done_edge;
    logic [7:0] tbl;
    logic       pss;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic start0, start1;
  logic a0, b0, c0, a1, b1, c1;
  logic f_in0, f_in1;
  logic busy0, done0, pass0, busy1, done1, pass1;
  logic [7:0] table0, table1;

  logic stuck0 = 1'b0;
  logic glitch_on = 1'b0;
  int   g_base = -1000;
  int   rel1;
  int   edge_n = 0;
  int   n_chk = 0;
  int   n_err = 0;
  exp_t sb0[$];
  exp_t sb1[$];

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  function_sweep_controller #(.SETTLE_CYCLES(2), .EXPECTED(8'h4F)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .a(a0), .b(b0), .c(c0),
    .f_in(f_in0), .busy(busy0), .done(done0), .table_out(table0), .pass(pass0)
  );

  function_sweep_controller #(.SETTLE_CYCLES(1), .EXPECTED(8'h4F)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .a(a1), .b(b1), .c(c1),
    .f_in(f_in1), .busy(busy1), .done(done1), .table_out(table1), .pass(pass1)
  );

  // Function under test: f = a' + bc', optionally stuck at 1.
  assign f_in0 = stuck0 ? 1'b1 : (~a0 | (b0 & ~c0));

  // Inverted during every settle cycle of the dut1 sweep, correct while sampled.
  always @(negedge clk) begin
    rel1  = edge_n - g_base;
    f_in1 = (~a1 | (b1 & ~c1)) ^ (glitch_on && rel1 >= 0 && rel1 < 16 && (rel1 % 2) == 0);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done0) begin
      if (sb0.size() == 0) chk("d0_unexpected", 1, 0);
      else begin
        e = sb0.pop_front();
        chk("d0_edge", edge_n, e.done_edge);
        chk("d0_table", table0, e.tbl);
        chk("d0_pass", pass0, e.pss);
      end
    end
    if (done1) begin
      if (sb1.size() == 0) chk("d1_unexpected", 1, 0);
      else begin
        e = sb1.pop_front();
        chk("d1_edge", edge_n, e.done_edge);
        chk("d1_table", table1, e.tbl);
        chk("d1_pass", pass1, e.pss);
      end
    end
  end

  task automatic launch0(input logic [7:0] tbl, input logic pss);
    exp_t e;
    start0 = 1'b1;
    e.done_edge = edge_n + 1 + 24;
    e.tbl = tbl;
    e.pss = pss;
    sb0.push_back(e);
    @(negedge clk);
    start0 = 1'b0;
    chk("busy_on_accept", busy0, 1);
  endtask

  task automatic drain0(input int budget);
    int n = 0;
    while (sb0.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain0", sb0.size(), 0);
  endtask

  task automatic drain1(input int budget);
    int n = 0;
    while (sb1.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain1", sb1.size(), 0);
  endtask

  initial begin
    exp_t e;
    int   base;
    reset  = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_out0", {a0, b0, c0, busy0, done0, pass0, table0}, 0);
    chk("reset_out1", {a1, b1, c1, busy1, done1, pass1, table1}, 0);
    reset = 1'b0;
    @(negedge clk);

    // Good function: full sweep, pass, results held afterwards.
    launch0(8'h4F, 1'b1);
    drain0(100);
    repeat (3) @(negedge clk);
    chk("hold_table", table0, 8'h4F);
    chk("hold_pass", pass0, 1);
    chk("idle_busy", busy0, 0);
    chk("abc_hold_111", {a0, b0, c0}, 3'b111);

    // Stuck-at-1 function.
    stuck0 = 1'b1;
    launch0(8'hFF, 1'b0);
    drain0(100);
    stuck0 = 1'b0;
    @(negedge clk);
    chk("stuck_hold_pass", pass0, 0);

    // Start pulse mid-sweep is ignored; exactly one done at 24.
    launch0(8'h4F, 1'b1);
    repeat (4) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    drain0(100);
    repeat (30) @(negedge clk);
    chk("ignored_start_idle", busy0, 0);

    // Reset mid-sweep clears everything at once; fresh sweep afterwards.
    launch0(8'h4F, 1'b1);
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1 chk("abort_out0", {a0, b0, c0, busy0, done0, pass0, table0}, 0);
    sb0.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    launch0(8'h4F, 1'b1);
    drain0(100);

    // Start held for 60 cycles: sweeps chained at 25-cycle intervals.
    start0 = 1'b1;
    base = edge_n + 1;
    for (int k = 0; k < 3; k++) begin
      e.done_edge = base + 24 + 25 * k;
      e.tbl = 8'h4F;
      e.pss = 1'b1;
      sb0.push_back(e);
    end
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (k == 25) begin
        chk("b2b_table_clear", table0, 0);
        chk("b2b_busy", busy0, 1);
      end
    end
    start0 = 1'b0;
    drain0(100);

    // One-cycle settle with glitches confined to settle cycles.
    glitch_on = 1'b1;
    start1 = 1'b1;
    g_base = edge_n + 1;
    e.done_edge = g_base + 16;
    e.tbl = 8'h4F;
    e.pss = 1'b1;
    sb1.push_back(e);
    @(negedge clk);
    start1 = 1'b0;
    chk("busy1_on_accept", busy1, 1);
    drain1(100);
    glitch_on = 1'b0;
    repeat (5) @(negedge clk);
    chk("glitch_hold_table", table1, 8'h4F);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
